// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Shares one register-file write port between two producers:
//   * load data returning from memory. It can never be stalled, so it always
//     wins the port.
//   * ALU results. A small FIFO holds any result that loses arbitration, and
//     alu_ready pushes back on the ALU when that FIFO is full.
//
// Each cycle one source is chosen, in this fixed order: the load, then the
// FIFO head, then the incoming ALU result. An incoming ALU result can only
// skip the FIFO when the FIFO is empty. All writeback outputs are registered,
// so a chosen write appears one cycle after the cycle that chose it.
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   alu_valid/alu_rd/alu_result ALU result offer (valid/ready handshake)
//   alu_ready                   combinational; high while the FIFO has room
//   ld_valid/ld_rd/ld_data      load return (no back-pressure)
//   RegWrite, Write_Reg         register file write enable / address
//   MemToReg                    writeback mux select (1 = Read_Data)
//   Read_Data, ALU_Result       data operands for the writeback mux
//   q_count                     current ALU FIFO occupancy
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [REG_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [REG_W-1:0]         ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     RegWrite,
  output logic [REG_W-1:0]         Write_Reg,
  output logic                     MemToReg,
  output logic [DATA_W-1:0]        Read_Data,
  output logic [DATA_W-1:0]        ALU_Result,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LOAD,
    SEL_QUEUE,
    SEL_BYPASS
  } sel_e;

  // FIFO storage and control
  logic [REG_W-1:0]  r_q_rd   [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Registered writeback outputs
  logic              r_reg_write;
  logic [REG_W-1:0]  r_write_reg;
  logic              r_mem_to_reg;
  logic [DATA_W-1:0] r_read_data;
  logic [DATA_W-1:0] r_alu_result;

  sel_e              w_sel;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [REG_W-1:0]  w_wb_rd;
  logic [DATA_W-1:0] w_wb_data;

  // alu_ready depends only on the current occupancy. Letting a same-cycle pop
  // raise it would create a combinational path from ld_valid to alu_ready.
  assign alu_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept  = alu_valid && alu_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel     = SEL_NONE;
    w_pop     = 1'b0;
    w_push    = 1'b0;
    w_wb_rd   = r_q_rd[r_rd_ptr];
    w_wb_data = r_q_data[r_rd_ptr];
    if (ld_valid) begin
      w_sel = SEL_LOAD;
    end else if (r_count != '0) begin
      w_sel = SEL_QUEUE;
      w_pop = 1'b1;
    end else if (alu_valid) begin
      // The FIFO is empty here, so alu_ready is high and the result is accepted.
      w_sel     = SEL_BYPASS;
      w_wb_rd   = alu_rd;
      w_wb_data = alu_result;
    end
    // Any accepted result that was not bypassed goes to the FIFO tail.
    w_push = w_accept && (w_sel != SEL_BYPASS);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow wraps correctly.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset. After a reset the pointers and the count
  // mark every entry invalid, so old contents can never be read out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]   <= alu_rd;
      r_q_data[r_wr_ptr] <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_mem_to_reg <= 1'b0;
      r_read_data  <= '0;
      r_alu_result <= '0;
    end else begin
      unique case (w_sel)
        SEL_LOAD: begin
          // A write to r0 is consumed normally but never enables the write port.
          r_reg_write  <= (ld_rd != '0);
          r_write_reg  <= ld_rd;
          r_mem_to_reg <= 1'b1;
          r_read_data  <= ld_data;
        end
        SEL_QUEUE, SEL_BYPASS: begin
          r_reg_write  <= (w_wb_rd != '0);
          r_write_reg  <= w_wb_rd;
          r_mem_to_reg <= 1'b0;
          r_alu_result <= w_wb_data;
        end
        default: begin
          // No source this cycle: drop the enable and keep the datapath stable.
          r_reg_write <= 1'b0;
        end
      endcase
    end
  end

  assign RegWrite   = r_reg_write;
  assign Write_Reg  = r_write_reg;
  assign MemToReg   = r_mem_to_reg;
  assign Read_Data  = r_read_data;
  assign ALU_Result = r_alu_result;
  assign q_count    = r_count;

endmodule
